// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out frame transmitter.
// Optional parity support is enabled by defining PISO_PARITY_EN.
package piso_pkg;

  localparam int FRAME_W = 11;
  localparam int MAX_LEN = 12;
  localparam int CNT_W   = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_t;

  // Positions beyond the 11-bit frame read as 1, which supplies the second stop bit of a 12-bit frame.
  function automatic logic frame_bit(input logic [FRAME_W-1:0] frame, input cnt_t idx);
    logic [2**CNT_W-1:0] ext;
    ext = {{(2**CNT_W - FRAME_W){1'b1}}, frame};
    return ext[idx];
  endfunction

endpackage

// File: rtl/piso_len_dec.sv
// Decodes the frame format controls into frame length and parity bit position.
// Parity decode is present only when PISO_PARITY_EN is defined.
module piso_len_dec
  import piso_pkg::*;
(
  input  logic       data_length,
  input  logic       stop_bits,
  input  logic [1:0] parity_type,
  output cnt_t       frame_len,
  output cnt_t       parity_idx,
  output logic       parity_en
);

`ifdef PISO_PARITY_EN
  assign parity_en = (parity_t'(parity_type) == PAR_ODD) || (parity_t'(parity_type) == PAR_EVEN);
`else
  logic unused_parity;
  assign unused_parity = ^parity_type;
  assign parity_en     = 1'b0;
`endif

  assign frame_len  = cnt_t'(1)
                    + (data_length ? cnt_t'(8) : cnt_t'(7))
                    + {{(CNT_W-1){1'b0}}, parity_en}
                    + (stop_bits ? cnt_t'(2) : cnt_t'(1));
  assign parity_idx = data_length ? cnt_t'(9) : cnt_t'(8);

endmodule

// File: rtl/piso_reg.sv
// Frame transmitter: latches an assembled frame on send and shifts it out LSB-first, one bit per BaudOut cycle.
// Parity handling is compiled in with PISO_PARITY_EN.
module piso_reg
  import piso_pkg::*;
(
  input  logic               BaudOut,
  input  logic               rst,
  input  logic               send,
  input  logic [FRAME_W-1:0] FrameOut,
  input  logic               data_length,
  input  logic               stop_bits,
  input  logic [1:0]         parity_type,
  output logic               data_out,
  output logic               p_parity_out,
  output logic               tx_active,
  output logic               tx_done
);

  state_t             state, state_nxt;
  cnt_t               bit_cnt;
  cnt_t               len_q;
  logic [FRAME_W-1:0] frame_q;
  cnt_t               dec_len, dec_pidx;
  logic               dec_pen;
  logic               load, last_bit;

  piso_len_dec u_len_dec (
    .data_length (data_length),
    .stop_bits   (stop_bits),
    .parity_type (parity_type),
    .frame_len   (dec_len),
    .parity_idx  (dec_pidx),
    .parity_en   (dec_pen)
  );

  assign load     = (state == ST_IDLE) && send;
  assign last_bit = (bit_cnt == len_q - cnt_t'(1));

  always_ff @(posedge BaudOut) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge BaudOut) begin
    if (rst) begin
      bit_cnt      <= '0;
      p_parity_out <= 1'b0;
    end else if (load) begin
      bit_cnt      <= '0;
      p_parity_out <= dec_pen & FrameOut[dec_pidx];
    end else if (state == ST_ACTIVE && !last_bit) begin
      bit_cnt      <= bit_cnt + cnt_t'(1);
    end
  end

  // NOTE: frame and length holders need no reset; they are only observed while ACTIVE, which always follows a load.
  always_ff @(posedge BaudOut) begin
    if (load) begin
      frame_q <= FrameOut;
      len_q   <= dec_len;
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (send) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    data_out  = 1'b1;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    case (state)
      ST_ACTIVE: begin
        data_out  = frame_bit(frame_q, bit_cnt);
        tx_active = 1'b1;
      end
      ST_DONE: tx_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_reg.sv
// Directed bench for piso_reg: expected serial bits are queued when a frame is set up and popped as the line shifts.
// Expectations follow the PISO_PARITY_EN build setting.
module tb_piso_reg;

  logic        BaudOut;
  logic        rst;
  logic        send;
  logic [10:0] FrameOut;
  logic        data_length;
  logic        stop_bits;
  logic [1:0]  parity_type;
  logic        data_out;
  logic        p_parity_out;
  logic        tx_active;
  logic        tx_done;

  int   total;
  int   bad;
  logic exp_q[$];
  logic exp_par;

  piso_reg dut (
    .BaudOut      (BaudOut),
    .rst          (rst),
    .send         (send),
    .FrameOut     (FrameOut),
    .data_length  (data_length),
    .stop_bits    (stop_bits),
    .parity_type  (parity_type),
    .data_out     (data_out),
    .p_parity_out (p_parity_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done)
  );

  initial BaudOut = 1'b0;
  always #5 BaudOut = ~BaudOut;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit par_on(input logic [1:0] pt);
`ifdef PISO_PARITY_EN
    return (pt == 2'b01) || (pt == 2'b10);
`else
    return (pt == 2'b11) && 1'b0;
`endif
  endfunction

  // Drive the frame controls and queue the bits the line should carry.
  task automatic push_frame(input logic [10:0] fo, input logic dl, input logic sb, input logic [1:0] pt);
    int nd;
    int len;
    FrameOut    = fo;
    data_length = dl;
    stop_bits   = sb;
    parity_type = pt;
    nd  = dl ? 8 : 7;
    len = 1 + nd + (par_on(pt) ? 1 : 0) + (sb ? 2 : 1);
    for (int i = 0; i < len; i++) exp_q.push_back(i < 11 ? fo[i] : 1'b1);
    exp_par = par_on(pt) ? fo[1 + nd] : 1'b0;
  endtask

  task automatic drain_bits(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge BaudOut);
      check({tag, "_active"}, 32'(tx_active), 32'd1);
      if (exp_q.size() > 0) check({tag, "_bit"}, 32'(data_out), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge BaudOut);
    check({tag, "_done"},     32'(tx_done),      32'd1);
    check({tag, "_inactive"}, 32'(tx_active),    32'd0);
    check({tag, "_stop_idle"},32'(data_out),     32'd1);
    check({tag, "_parity"},   32'(p_parity_out), 32'(exp_par));
  endtask

  task automatic check_idle(input string tag);
    @(negedge BaudOut);
    check({tag, "_idle_done"},   32'(tx_done),   32'd0);
    check({tag, "_idle_active"}, 32'(tx_active), 32'd0);
    check({tag, "_idle_line"},   32'(data_out),  32'd1);
  endtask

  task automatic send_pulse();
    send = 1'b1;
    @(posedge BaudOut);
    #1 send = 1'b0;
  endtask

  initial begin
    int done_seen;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    send        = 1'b0;
    FrameOut    = '0;
    data_length = 1'b0;
    stop_bits   = 1'b0;
    parity_type = 2'b00;
    exp_par     = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge BaudOut);
    @(negedge BaudOut);
    check("rst_line",   32'(data_out),     32'd1);
    check("rst_active", 32'(tx_active),    32'd0);
    check("rst_done",   32'(tx_done),      32'd0);
    check("rst_parity", 32'(p_parity_out), 32'd0);
    rst = 1'b0;

    // 8 data bits, no parity, one stop bit.
    push_frame(11'b11010010100, 1'b1, 1'b0, 2'b00);
    send_pulse();
    drain_bits("f8n1", exp_q.size());
    check_done("f8n1");
    check_idle("f8n1");

    // Odd parity selected.
    push_frame(11'b10010010100, 1'b1, 1'b0, 2'b01);
    send_pulse();
    drain_bits("f8o1", exp_q.size());
    check_done("f8o1");
    check_idle("f8o1");

    // Even parity, two stop bits: the longest frame, last bit comes from outside FrameOut.
    push_frame(11'b11010010100, 1'b1, 1'b1, 2'b10);
    send_pulse();
    drain_bits("f8e2", exp_q.size());
    check_done("f8e2");
    check_idle("f8e2");

    // 7 data bits, two stop bits, send held high across two frames.
    push_frame(11'b11110000100, 1'b0, 1'b1, 2'b00);
    send = 1'b1;
    @(posedge BaudOut);
    drain_bits("f7n2", exp_q.size());
    check_done("f7n2");
    push_frame(11'b10101010110, 1'b0, 1'b0, 2'b01);
    check_idle("hold_gap");
    drain_bits("hold_next", exp_q.size());
    send = 1'b0;
    check_done("hold_next");
    check_idle("hold_next");

    // Abort by reset at edge 5; inputs change mid-frame and must not leak into the line.
    push_frame(11'b01101011010, 1'b1, 1'b1, 2'b10);
    send_pulse();
    drain_bits("abort", 1);
    FrameOut    = ~FrameOut;
    data_length = 1'b0;
    stop_bits   = 1'b0;
    parity_type = 2'b00;
    drain_bits("abort", 4);
    rst = 1'b1;
    @(negedge BaudOut);
    check("abort_line",   32'(data_out),     32'd1);
    check("abort_active", 32'(tx_active),    32'd0);
    check("abort_done",   32'(tx_done),      32'd0);
    check("abort_parity", 32'(p_parity_out), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge BaudOut);
      if (tx_done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_reg.md
PISO_REG -- requirements
Module: piso_reg

Interface
REQ-001 BaudOut  input  1  bit clock; all state updates on its rising edge; one bit period per cycle.
REQ-002 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-003 send  input  1  level request to start a frame; sampled only in IDLE.
REQ-004 FrameOut  input  11  assembled frame; bit 0 = start bit, then data LSB-first, then optional parity, then stop bits.
REQ-005 data_length  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 stop_bits  input  1  1 = two stop bits, 0 = one stop bit.
REQ-007 parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-008 data_out  output  1  serial line; idle high.
REQ-009 p_parity_out  output  1  parity bit of the latched frame, presented in parallel.
REQ-010 tx_active  output  1  high while frame bits are driven.
REQ-011 tx_done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-012 Frame length L = 1 + (data_length ? 8 : 7) + (parity_type in {01,10} ? 1 : 0) + (stop_bits ? 2 : 1); range 9..12.
REQ-013 States IDLE, ACTIVE, DONE; IDLE -> ACTIVE on rising edge with send=1; ACTIVE -> DONE after bit L-1; DONE -> IDLE next edge.
REQ-014 Load edge latches FrameOut, data_length, stop_bits, parity_type; later input changes do not affect the frame in flight.
REQ-015 Bit i (0..L-1) is driven on data_out from load edge + i to load edge + i + 1; load edge drives FrameOut[0].
REQ-016 For L = 12, bit 11 is not in FrameOut and is driven as 1 (second stop bit).
REQ-017 tx_active = 1 exactly during bits 0..L-1; 0 in IDLE and DONE.
REQ-018 tx_done = 1 for exactly the one DONE cycle (load edge + L to + L + 1); data_out = 1 then.
REQ-019 p_parity_out = latched FrameOut[1 + data bits] when parity enabled, else 0; updated at load edge, held until next load or reset.
REQ-020 send held high: a new frame loads on the first IDLE edge after DONE (one idle cycle between frames minimum).
REQ-021 send ignored in ACTIVE and DONE; no FrameOut checking (start/stop values transmitted as given).

Reset
REQ-022 rst=1 at rising edge: state IDLE, bit counter 0, data_out=1, tx_active=0, tx_done=0, p_parity_out=0.
REQ-023 rst mid-frame aborts the frame; no tx_done pulse; rst has priority over send.

Configuration
REQ-024 Macro PISO_PARITY_EN: defined -> parity per REQ-007/REQ-019; undefined -> parity_type ignored (treated as 00), L excludes parity, p_parity_out tied 0.

Structure
REQ-025 Package piso_pkg holds: state enum, parity_type encodings, frame width constant 11, max length constant 12, counter width 4.
REQ-026 One sub-module piso_len_dec: combinational decode of data_length/stop_bits/parity_type to L and parity index.

Verification
REQ-027 Reset: rst=1 for 2 edges -> data_out=1, tx_active=0, tx_done=0, p_parity_out=0.
REQ-028 stop=0, data_length=1, parity 00, FrameOut=11'b11010010100, send pulse -> data_out bits 0..9 = 0,0,1,0,1,0,0,1,0,1; tx_done at edge 10; p_parity_out=0.
REQ-029 stop=0, data_length=1, parity 01, FrameOut=11'b10010010100 -> 11 bits 0,0,1,0,1,0,0,1,0,0,1; p_parity_out=0; tx_done at edge 11.
REQ-030 stop=1, data_length=1, parity 10, FrameOut=11'b11010010100 -> 11 FrameOut bits then bit 11 = 1; p_parity_out=1; tx_done at edge 12.
REQ-031 stop=1, data_length=0, parity 00, FrameOut=11'b11110000100 -> L=10, bits 0,0,1,0,0,0,0,1,1,1; send held high -> next frame loads one cycle after tx_done.
REQ-032 rst=1 at edge 5 of a frame -> next cycle data_out=1, tx_active=0, no tx_done pulse; inputs changed mid-frame do not alter transmitted bits.
